// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Generates sequential fetch addresses and keeps at most one request
// outstanding to instruction memory over a ready/valid handshake. Returned
// instructions are buffered with their PCs in a DEPTH-entry in-order queue.
// A redirect flushes the queue and marks any outstanding response as stale.
//
// Ports:
//   clk, rstd            clock, synchronous active-high reset
//   imem_req/imem_addr   fetch request valid / address
//   imem_ready           memory accepts the request this cycle
//   imem_rvalid/rdata    in-order response, one per accepted request
//   redirect/redirect_pc flush and restart fetch at redirect_pc
//   out_valid/out_ready  decode handshake on the queue head
//   out_ins/out_pc       head instruction and its PC
//   count                occupied queue entries
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rstd,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [XLEN-1:0]              imem_rdata,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_ins,
  output logic [XLEN-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_pending;
  logic [XLEN-1:0] r_req_pc;
  logic            r_drop;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_q_pc  [DEPTH];
  logic [XLEN-1:0] r_q_ins [DEPTH];

  logic [CW:0]     w_used;
  logic            w_resp;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;

  // The reserved slot of an outstanding request counts against capacity even
  // when its response returns this cycle; a same-cycle pop does not free one.
  assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
  assign imem_req = !rstd && !redirect && (!r_pending || imem_rvalid) &&
                    (w_used < LP_DEPTH);
  assign imem_addr = r_fetch_pc;

  assign w_accept = imem_req && imem_ready;
  assign w_resp   = imem_rvalid && r_pending;
  assign w_push   = w_resp && !r_drop && !redirect && !rstd;
  assign w_pop    = out_valid && out_ready && !redirect && !rstd;
  assign w_full   = ({1'b0, r_count} == LP_DEPTH);

  assign out_valid = (r_count != '0);
  assign out_ins   = r_q_ins[r_rd_ptr];
  assign out_pc    = r_q_pc[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rstd) begin
      r_fetch_pc <= RESET_PC;
      r_pending  <= 1'b0;
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= r_wr_ptr;
      if (w_resp) begin
        // Response arriving with the redirect is discarded outright.
        r_pending <= 1'b0;
        r_drop    <= 1'b0;
      end else if (r_pending) begin
        r_drop <= 1'b1;
      end
    end else begin
      if (w_accept) begin
        r_pending  <= 1'b1;
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      end else if (w_resp) begin
        r_pending <= 1'b0;
      end
      if (w_resp && r_drop) begin
        r_drop <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]  <= r_req_pc;
      r_q_ins[r_wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      assert (!(w_push && w_full && !w_pop));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rstd;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [2:0]  count;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .PC_STEP  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rstd        (rstd),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_pc      (out_pc),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference model: expected queue contents, next fetch address, stale flag.
  ent_t        refq[$];
  logic [31:0] ref_fpc;
  bit          ref_stale;

  // Memory model: single outstanding request with programmable latency.
  bit          mem_busy;
  int unsigned mem_wait;
  logic [31:0] mem_addr;

  // Stimulus knobs (percentages / latency range).
  int unsigned lat_min, lat_max;
  int unsigned p_ready, p_oready, p_redir, p_rst, p_spur;
  bit          force_redir;
  logic [31:0] force_pc;

  int unsigned n_checks;
  int unsigned n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit chance(input int unsigned pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic drive_inputs();
    rstd        = chance(p_rst);
    redirect    = force_redir || chance(p_redir);
    if (force_redir) redirect_pc = force_pc;
    else if (chance(25)) redirect_pc = 32'hFFFF_FFF8;
    else redirect_pc = $urandom & 32'hFFFF_FFFC;
    force_redir = 1'b0;
    imem_ready  = chance(p_ready);
    out_ready   = chance(p_oready);
    if (mem_busy && mem_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr ^ 32'hA5A5_0000;
    end else if (!mem_busy && chance(p_spur)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock: drive just after the rising edge, check on the falling edge,
  // then advance the model to match the next rising edge.
  task automatic cycle();
    bit rv, exp_req, acc;
    drive_inputs();
    @(negedge clk);
    rv      = imem_rvalid && mem_busy;
    exp_req = !rstd && !redirect && (!mem_busy || imem_rvalid) &&
              (refq.size() + int'(mem_busy) < DEPTH);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, ref_fpc);
    check_eq("count", {29'b0, count}, refq.size());
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, refq.size() != 0});
    if (refq.size() != 0) begin
      check_eq("out_pc", out_pc, refq[0].pc);
      check_eq("out_ins", out_ins, refq[0].ins);
    end
    acc = exp_req && imem_ready;
    if (rstd) begin
      refq.delete();
      ref_fpc   = 32'h0;
      ref_stale = 1'b0;
      mem_busy  = 1'b0;
      mem_wait  = 0;
    end else begin
      if (redirect) begin
        refq.delete();
        ref_fpc = redirect_pc;
        if (rv) ref_stale = 1'b0;
        else if (mem_busy) ref_stale = 1'b1;
      end else begin
        if (refq.size() != 0 && out_ready) void'(refq.pop_front());
        if (rv) begin
          if (ref_stale) ref_stale = 1'b0;
          else refq.push_back('{mem_addr, imem_rdata});
        end
      end
      if (rv) mem_busy = 1'b0;
      else if (mem_busy && mem_wait > 0) mem_wait--;
      if (acc) begin
        mem_busy = 1'b1;
        mem_addr = ref_fpc;
        mem_wait = $urandom_range(lat_max, lat_min) - 1;
        ref_fpc  = ref_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    force_redir = 1'b0;
    force_pc    = '0;
    rstd        = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    out_ready   = 1'b0;
    refq.delete();
    ref_fpc   = 32'h0;
    ref_stale = 1'b0;
    mem_busy  = 1'b0;
    mem_wait  = 0;
    mem_addr  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Streaming with a 1-cycle memory and an always-ready consumer.
    lat_min = 1; lat_max = 1;
    p_ready = 100; p_oready = 100; p_redir = 0; p_rst = 0; p_spur = 0;
    run(30);

    // Consumer stalled until the queue fills, then released.
    p_oready = 0;
    run(12);
    p_oready = 100;
    run(12);

    // 3-cycle memory with redirects landing on outstanding requests.
    lat_min = 3; lat_max = 3; p_redir = 10;
    run(150);

    // Address wrap at the top of the address space.
    lat_min = 1; lat_max = 1; p_redir = 0;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF4;
    run(20);

    // Random stalls, redirects, resets and spurious responses.
    lat_min = 1; lat_max = 3;
    p_ready = 70; p_oready = 60; p_redir = 5; p_rst = 2; p_spur = 15;
    run(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
